// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator display conversion path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package calc_pkg;

    // Conversion scheduler states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Seven-segment sign digit codes.
    localparam logic [3:0] SIGN_MINUS = 4'hB;
    localparam logic [3:0] SIGN_BLANK = 4'hF;

    // Requester identifiers, also used as the round-robin history value.
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left by one.
// Latency: combinational.
// Backpressure: none (pure function of sr_in).
//
// Ports:
//   sr_in  - {bcd digits, binary remainder}, digit 0 sits just above the binary field
//   sr_out - corrected and shifted register
module bcd_dabble_step #(
    parameter int WIDTH  = 21,
    parameter int DIGITS = 8
) (
    input  logic [4*DIGITS+WIDTH-1:0] sr_in,
    output logic [4*DIGITS+WIDTH-1:0] sr_out
);

    logic [4*DIGITS+WIDTH-1:0] adj;

    always_comb begin
        adj = sr_in;
        for (int i = 0; i < DIGITS; i++) begin
            if (sr_in[WIDTH+4*i +: 4] >= 4'd5) begin
                adj[WIDTH+4*i +: 4] = sr_in[WIDTH+4*i +: 4] + 4'd3;
            end
        end
        // The MSB falls off; DIGITS is sized so it is always zero here.
        sr_out = adj << 1;
    end

endmodule

// File: rtl/bcd_conv_sched.sv
// Arbitrated signed binary-to-BCD converter sharing one double-dabble datapath between ports A and B.
// Latency: outputs and done update WIDTH+1 cycles after the acceptance edge; one conversion per WIDTH+2 cycles.
// Backpressure: ack_x only asserts in IDLE; requests raised while busy wait with ack low.
//
// Ports:
//   clk, reset_n        - rising-edge clock, asynchronous active-low reset
//   req_a/bin_a/ack_a   - operand-entry requester (level request, value held until ack)
//   req_b/bin_b/ack_b   - ALU-result requester
//   busy                - conversion in flight (SHIFT or DONE)
//   done                - one-cycle pulse when bcd/sign_dig/src are refreshed
//   src                 - requester of the latched result (0=A, 1=B)
//   bcd                 - magnitude digits, digit 0 in [3:0]
//   sign_dig            - 4'hB for negative, 4'hF for zero/positive
module bcd_conv_sched
    import calc_pkg::*;
#(
    parameter int WIDTH  = 21,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_a,
    input  logic [WIDTH-1:0]      bin_a,
    output logic                  ack_a,
    input  logic                  req_b,
    input  logic [WIDTH-1:0]      bin_b,
    output logic                  ack_b,
    output logic                  busy,
    output logic                  done,
    output logic                  src,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [3:0]            sign_dig
);

    localparam int SRW = 4*DIGITS + WIDTH;
    localparam int CW  = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [SRW-1:0]   sr, sr_step;
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             cur_src;
    logic             last_grant;

    logic             grant_a, grant_b, accept;
    logic [WIDTH-1:0] sel_bin, mag;

    // Round-robin: on a tie, A wins unless A was served last.
    always_comb begin
        grant_a = req_a && (!req_b || (last_grant == SRC_B));
        grant_b = req_b && !grant_a;
        accept  = (state == IDLE) && (req_a || req_b);
        sel_bin = grant_a ? bin_a : bin_b;
        // Unsigned negation in WIDTH bits: the most-negative value maps to 2^(WIDTH-1) without wrap.
        mag     = sel_bin[WIDTH-1] ? -sel_bin : sel_bin;
    end

    bcd_dabble_step #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_step (
        .sr_in  (sr),
        .sr_out (sr_step)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Combinational outputs. ack is gated by reset so it reads low while reset is held.
    always_comb begin
        ack_a = reset_n && (state == IDLE) && grant_a;
        ack_b = reset_n && (state == IDLE) && grant_b;
        busy  = (state != IDLE);
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr         <= '0;
            cnt        <= '0;
            neg_q      <= 1'b0;
            cur_src    <= SRC_A;
            last_grant <= SRC_B;
            done       <= 1'b0;
            src        <= SRC_A;
            bcd        <= '0;
            sign_dig   <= SIGN_BLANK;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sr         <= SRW'(mag);
                        cnt        <= '0;
                        neg_q      <= sel_bin[WIDTH-1];
                        cur_src    <= grant_a ? SRC_A : SRC_B;
                        last_grant <= grant_a ? SRC_A : SRC_B;
                    end
                end
                SHIFT: begin
                    sr  <= sr_step;
                    cnt <= cnt + CW'(1);
                end
                DONE: begin
                    bcd      <= sr[SRW-1 -: 4*DIGITS];
                    sign_dig <= neg_q ? SIGN_MINUS : SIGN_BLANK;
                    src      <= cur_src;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Self-checking bench for bcd_conv_sched: directed vector table, random values against a
// decimal-division reference, and hand-written arbitration / backpressure / reset sequences.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_bcd_conv_sched;

    localparam int W = 21;
    localparam int D = 8;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           req_a = 1'b0;
    logic [W-1:0]   bin_a = '0;
    logic           req_b = 1'b0;
    logic [W-1:0]   bin_b = '0;
    logic           ack_a, ack_b, busy, done, src;
    logic [4*D-1:0] bcd;
    logic [3:0]     sign_dig;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_conv_sched #(.WIDTH(W), .DIGITS(D)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_a    (req_a),
        .bin_a    (bin_a),
        .ack_a    (ack_a),
        .req_b    (req_b),
        .bin_b    (bin_b),
        .ack_b    (ack_b),
        .busy     (busy),
        .done     (done),
        .src      (src),
        .bcd      (bcd),
        .sign_dig (sign_dig)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog timeout");
    end

    typedef struct {
        logic        port;
        logic [W-1:0] val;
        logic [31:0] exp_bcd;
        logic [3:0]  exp_sign;
        string       name;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: decimal digits of |v| by repeated division.
    function automatic logic [31:0] model_bcd(input int v);
        int          m;
        logic [31:0] r;
        m = (v < 0) ? -v : v;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            r[4*k +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] model_sign(input int v);
        return (v < 0) ? 4'hB : 4'hF;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // which: 0 = A acked, 1 = B acked, -1 = no ack within budget.
    task automatic wait_ack(output int which);
        which = -1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (ack_a) begin which = 0; break; end
            if (ack_b) begin which = 1; break; end
            step();
        end
    endtask

    // Entered one unit after the acceptance edge; lat counts edges until done is seen.
    task automatic wait_done(output int lat, output bit ack_bad);
        lat = 0;
        ack_bad = 1'b0;
        while (!done && lat < 100) begin
            if (busy && (ack_a || ack_b)) ack_bad = 1'b1;
            step();
            lat++;
        end
    endtask

    task automatic run_conv(input logic port, input logic [W-1:0] val,
                            input logic [31:0] eb, input logic [3:0] es, input string name);
        int which, lat;
        bit ab;
        if (port == 1'b0) begin bin_a = val; req_a = 1'b1; end
        else              begin bin_b = val; req_b = 1'b1; end
        wait_ack(which);
        check({name, " ack port"}, which, {31'd0, port});
        step();
        req_a = 1'b0;
        req_b = 1'b0;
        check({name, " busy after accept"}, busy, 1);
        wait_done(lat, ab);
        check({name, " latency"}, lat, 22);
        check({name, " bcd"}, bcd, eb);
        check({name, " sign"}, sign_dig, es);
        check({name, " src"}, src, port);
        step();
        check({name, " done width"}, done, 0);
    endtask

    initial begin
        vec_t vecs[5];
        int   which, lat, v;
        bit   ab;
        logic [W-1:0] r;
        logic p;

        vecs[0] = '{1'b0, 21'd12345,       32'h00012345, 4'hF, "a_12345"};
        vecs[1] = '{1'b1, 21'(-999999),    32'h00999999, 4'hB, "b_neg999999"};
        vecs[2] = '{1'b0, 21'd0,           32'h00000000, 4'hF, "a_zero"};
        vecs[3] = '{1'b0, 21'h100000,      32'h01048576, 4'hB, "a_most_neg"};
        vecs[4] = '{1'b0, 21'd1048575,     32'h01048575, 4'hF, "a_max_pos"};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst ack_a", ack_a, 0);
        check("rst ack_b", ack_b, 0);
        check("rst src", src, 0);
        check("rst bcd", bcd, 0);
        check("rst sign", sign_dig, 4'hF);
        reset_n = 1'b1;
        step();

        // Directed vectors.
        for (int i = 0; i < 5; i++) begin
            run_conv(vecs[i].port, vecs[i].val, vecs[i].exp_bcd, vecs[i].exp_sign, vecs[i].name);
        end

        // Random values against the reference model.
        for (int i = 0; i < 16; i++) begin
            p = 1'($urandom_range(0, 1));
            r = W'($urandom);
            v = $signed(r);
            repeat ($urandom_range(0, 3)) step();
            run_conv(p, r, model_bcd(v), model_sign(v), "rand");
        end

        // Make B the last served so the tie below must go to A first.
        run_conv(1'b1, 21'd42, 32'h42, 4'hF, "pre_tie_b");

        // Tie: both held, service alternates A, B, A and no ack while busy.
        bin_a = 21'd7;
        bin_b = 21'(-3);
        req_a = 1'b1;
        req_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_ack(which);
            check("tie order", which, (k % 2));
            step();
            wait_done(lat, ab);
            check("tie no ack while busy", ab, 0);
            check("tie latency", lat, 22);
            check("tie bcd", bcd, (k % 2 == 0) ? 32'h7 : 32'h3);
            check("tie sign", sign_dig, (k % 2 == 0) ? 4'hF : 4'hB);
            check("tie src", src, (k % 2));
        end
        req_a = 1'b0;
        req_b = 1'b0;
        step();

        // B raised 5 cycles into an A conversion waits until the IDLE cycle after done.
        bin_a = 21'd100;
        req_a = 1'b1;
        wait_ack(which);
        check("late a ack", which, 0);
        step();
        req_a = 1'b0;
        lat = 0;
        repeat (5) begin step(); lat++; end
        bin_b = 21'(-4321);
        req_b = 1'b1;
        ab = 1'b0;
        while (!done && lat < 100) begin
            #1;
            if (ack_b) ab = 1'b1;
            step();
            lat++;
        end
        check("late b held off", ab, 0);
        check("late a latency", lat, 22);
        check("late a bcd", bcd, 32'h100);
        #1;
        check("late b ack after done", ack_b, 1);
        step();
        req_b = 1'b0;
        wait_done(lat, ab);
        check("late b latency", lat, 22);
        check("late b bcd", bcd, 32'h4321);
        check("late b sign", sign_dig, 4'hB);
        check("late b src", src, 1);
        step();

        // Reset mid-conversion aborts; a pending A is served after release.
        bin_a = 21'd555;
        req_a = 1'b1;
        wait_ack(which);
        check("abort ack", which, 0);
        step();
        req_a = 1'b0;
        repeat (10) step();
        reset_n = 1'b0;
        bin_a = 21'd8765;
        req_a = 1'b1;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort bcd", bcd, 0);
        check("abort sign", sign_dig, 4'hF);
        check("abort src", src, 0);
        check("abort ack_a in reset", ack_a, 0);
        repeat (2) step();
        check("abort no done", done, 0);
        reset_n = 1'b1;
        run_conv(1'b0, 21'd8765, 32'h8765, 4'hF, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
